// File: rtl/atm_auth_controller.sv
// Card-session controller in front of the combinational account/PIN authenticator.
// It runs each session through lookup, PIN attempts and an active session, and keeps a per-account lockout table.
module atm_auth_controller #(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_card_in,
  input  logic [3:0]  i_acc_num,
  input  logic        i_pin_valid,
  input  logic [15:0] i_pin,
  input  logic        i_activity,
  input  logic        i_logout,
  input  logic        i_admin_unlock,
  input  logic [3:0]  i_unlock_index,
  output logic [3:0]  o_auth_acc_num,
  output logic [15:0] o_auth_pin,
  input  logic [3:0]  i_auth_index,
  input  logic        i_auth_found,
  input  logic        i_auth_ok,
  output logic        o_session_active,
  output logic [3:0]  o_acc_index,
  output logic [1:0]  o_tries_left,
  output logic        o_pin_ok,
  output logic        o_pin_fail,
  output logic        o_card_rejected,
  output logic        o_locked_out,
  output logic        o_timeout,
  output logic        o_eject
);

  localparam int          TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  TRIES_INIT = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT_PIN,
    ST_CHECK,
    ST_ACTIVE,
    ST_EJECT
  } state_t;

  state_t        r_state;
  logic [3:0]    r_auth_acc_num;
  logic [15:0]   r_auth_pin;
  logic [3:0]    r_acc_index;
  logic [1:0]    r_tries_left;
  logic [TW-1:0] r_timer;
  logic          r_session_active;
  logic          r_eject;
  logic          r_pin_ok;
  logic          r_pin_fail;
  logic          r_card_rejected;
  logic          r_locked_out;
  logic          r_timeout;
  logic          r_lock [NUM_ACCOUNTS];

  logic w_idx_in_range;
  logic w_lookup_ok;
  logic w_timer_done;
  logic w_last_try;
  logic w_lock_set;

  // An index the table does not cover is treated as unusable, never as unlocked.
  assign w_idx_in_range = (32'(i_auth_index) < NUM_ACCOUNTS);
  assign w_lookup_ok    = i_auth_found && w_idx_in_range && !r_lock[i_auth_index];
  assign w_timer_done   = (r_timer == TIMER_MAX);
  assign w_last_try     = (r_tries_left <= 2'd1);
  assign w_lock_set     = (r_state == ST_CHECK) && i_card_in && !i_auth_ok && w_last_try;

  // Each lock bit has its own flop; a set in the same cycle as an unlock wins.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_lock
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lock[gi] <= 1'b0;
        end else if (w_lock_set && (r_acc_index == 4'(gi))) begin
          r_lock[gi] <= 1'b1;
        end else if (i_admin_unlock && (i_unlock_index == 4'(gi))) begin
          r_lock[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_auth_acc_num   <= '0;
      r_auth_pin       <= '0;
      r_acc_index      <= '0;
      r_tries_left     <= '0;
      r_timer          <= '0;
      r_session_active <= 1'b0;
      r_eject          <= 1'b0;
      r_pin_ok         <= 1'b0;
      r_pin_fail       <= 1'b0;
      r_card_rejected  <= 1'b0;
      r_locked_out     <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_pin_ok        <= 1'b0;
      r_pin_fail      <= 1'b0;
      r_card_rejected <= 1'b0;
      r_locked_out    <= 1'b0;
      r_timeout       <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (i_card_in) begin
            r_auth_acc_num <= i_acc_num;
            r_state        <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (!i_card_in) begin
            r_state <= ST_IDLE;
          end else if (w_lookup_ok) begin
            r_acc_index  <= i_auth_index;
            r_tries_left <= TRIES_INIT;
            r_timer      <= '0;
            r_state      <= ST_WAIT_PIN;
          end else begin
            r_card_rejected <= 1'b1;
            r_eject         <= 1'b1;
            r_state         <= ST_EJECT;
          end
        end

        ST_WAIT_PIN: begin
          if (!i_card_in) begin
            r_state <= ST_IDLE;
          end else if (i_pin_valid) begin
            r_auth_pin <= i_pin;
            r_timer    <= '0;
            r_state    <= ST_CHECK;
          end else if (w_timer_done) begin
            r_timeout <= 1'b1;
            r_eject   <= 1'b1;
            r_state   <= ST_EJECT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_CHECK: begin
          if (!i_card_in) begin
            r_state <= ST_IDLE;
          end else if (i_auth_ok) begin
            r_pin_ok         <= 1'b1;
            r_timer          <= '0;
            r_session_active <= 1'b1;
            r_state          <= ST_ACTIVE;
          end else begin
            if (r_tries_left != 2'd0) begin
              r_tries_left <= r_tries_left - 2'd1;
            end
            if (w_last_try) begin
              r_locked_out <= 1'b1;
              r_eject      <= 1'b1;
              r_state      <= ST_EJECT;
            end else begin
              r_pin_fail <= 1'b1;
              r_timer    <= '0;
              r_state    <= ST_WAIT_PIN;
            end
          end
        end

        ST_ACTIVE: begin
          // Removal beats logout, and logout beats a simultaneous expiry.
          if (!i_card_in) begin
            r_session_active <= 1'b0;
            r_state          <= ST_IDLE;
          end else if (i_logout) begin
            r_session_active <= 1'b0;
            r_eject          <= 1'b1;
            r_state          <= ST_EJECT;
          end else if (i_activity) begin
            r_timer <= '0;
          end else if (w_timer_done) begin
            r_timeout        <= 1'b1;
            r_session_active <= 1'b0;
            r_eject          <= 1'b1;
            r_state          <= ST_EJECT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_EJECT: begin
          r_timer <= '0;
          if (!i_card_in) begin
            r_eject <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_session_active <= 1'b0;
          r_eject          <= 1'b0;
          r_state          <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_auth_acc_num   = r_auth_acc_num;
  assign o_auth_pin       = r_auth_pin;
  assign o_session_active = r_session_active;
  assign o_acc_index      = r_acc_index;
  assign o_tries_left     = r_tries_left;
  assign o_pin_ok         = r_pin_ok;
  assign o_pin_fail       = r_pin_fail;
  assign o_card_rejected  = r_card_rejected;
  assign o_locked_out     = r_locked_out;
  assign o_timeout        = r_timeout;
  assign o_eject          = r_eject;

endmodule

// File: tb/tb_atm_auth_controller.sv
// Bench for atm_auth_controller: a table of per-cycle vectors plus hand-written multi-cycle sequences.
// The account database model maps account n (1..10) to index n-1 with PIN 1111*n+123.
module tb_atm_auth_controller;

  localparam int TO = 1000;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_OK   = 5'b10000;
  localparam logic [4:0] P_FAIL = 5'b01000;
  localparam logic [4:0] P_REJ  = 5'b00100;
  localparam logic [4:0] P_LOCK = 5'b00010;
  localparam logic [4:0] P_TO   = 5'b00001;

  logic        clk;
  logic        rst_n;
  logic        card_in;
  logic [3:0]  acc_num;
  logic        pin_valid;
  logic [15:0] pin;
  logic        activity;
  logic        logout;
  logic        admin_unlock;
  logic [3:0]  unlock_index;
  logic [3:0]  auth_acc_num;
  logic [15:0] auth_pin;
  logic [3:0]  auth_index;
  logic        auth_found;
  logic        auth_ok;
  logic        session_active;
  logic [3:0]  acc_index;
  logic [1:0]  tries_left;
  logic        pin_ok;
  logic        pin_fail;
  logic        card_rejected;
  logic        locked_out;
  logic        timeout;
  logic        eject;

  int total = 0;
  int bad   = 0;

  atm_auth_controller #(
    .NUM_ACCOUNTS   (10),
    .MAX_TRIES      (3),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_card_in        (card_in),
    .i_acc_num        (acc_num),
    .i_pin_valid      (pin_valid),
    .i_pin            (pin),
    .i_activity       (activity),
    .i_logout         (logout),
    .i_admin_unlock   (admin_unlock),
    .i_unlock_index   (unlock_index),
    .o_auth_acc_num   (auth_acc_num),
    .o_auth_pin       (auth_pin),
    .i_auth_index     (auth_index),
    .i_auth_found     (auth_found),
    .i_auth_ok        (auth_ok),
    .o_session_active (session_active),
    .o_acc_index      (acc_index),
    .o_tries_left     (tries_left),
    .o_pin_ok         (pin_ok),
    .o_pin_fail       (pin_fail),
    .o_card_rejected  (card_rejected),
    .o_locked_out     (locked_out),
    .o_timeout        (timeout),
    .o_eject          (eject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational authenticator model.
  always_comb begin
    auth_found = (auth_acc_num >= 4'd1) && (auth_acc_num <= 4'd10);
    auth_index = auth_acc_num - 4'd1;
    auth_ok    = auth_found && (auth_pin == 16'(1111 * int'(auth_acc_num) + 123));
  end

  logic [4:0] pulses;
  assign pulses = {pin_ok, pin_fail, card_rejected, locked_out, timeout};

  typedef struct {
    logic        card;
    logic [3:0]  acc;
    logic        pv;
    logic [15:0] pin;
    logic        act;
    logic        lo;
    logic        unl;
    logic [3:0]  uidx;
    logic [4:0]  ep;
    logic        esa;
    logic        eej;
    logic [1:0]  etr;
    logic [3:0]  eidx;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic c, input logic [3:0] a, input logic pv, input logic [15:0] p,
                              input logic act, input logic lo, input logic unl, input logic [3:0] uidx,
                              input logic [4:0] ep, input logic esa, input logic eej,
                              input logic [1:0] etr, input logic [3:0] eidx);
    vec_t v;
    v.card = c;   v.acc = a;    v.pv = pv;   v.pin = p;
    v.act  = act; v.lo = lo;    v.unl = unl; v.uidx = uidx;
    v.ep   = ep;  v.esa = esa;  v.eej = eej; v.etr = etr; v.eidx = eidx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] ep, input logic esa, input logic eej,
                          input logic [1:0] etr, input logic [3:0] eidx);
    chk({tag, ".pulses"}, 32'(pulses), 32'(ep));
    chk({tag, ".session_active"}, 32'(session_active), 32'(esa));
    chk({tag, ".eject"}, 32'(eject), 32'(eej));
    chk({tag, ".tries_left"}, 32'(tries_left), 32'(etr));
    chk({tag, ".acc_index"}, 32'(acc_index), 32'(eidx));
    $display("%s: pulses=%b sa=%b ej=%b tries=%0d idx=%0d", tag, pulses, session_active, eject,
             tries_left, acc_index);
  endtask

  task automatic insert(input logic [3:0] a);
    card_in = 1'b1;
    acc_num = a;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pin_try(input logic [15:0] p, input logic unl, input logic [3:0] uidx);
    pin_valid = 1'b1;
    pin       = p;
    @(negedge clk);
    pin_valid    = 1'b0;
    admin_unlock = unl;
    unlock_index = uidx;
    @(negedge clk);
    admin_unlock = 1'b0;
  endtask

  task automatic remove_card();
    card_in = 1'b0;
    @(negedge clk);
  endtask

  // Counts cycles until the timeout pulse; the bound keeps a missing pulse from hanging the run.
  task automatic run_to_timeout(input int exp_ticks, input string name);
    int got;
    got = -1;
    for (int t = 1; t <= exp_ticks + 5; t++) begin
      @(negedge clk);
      if (timeout) begin
        got = t;
        break;
      end
    end
    chk({name, ".cycles"}, 32'(got), 32'(exp_ticks));
    chk({name, ".eject"}, 32'(eject), 32'd1);
    chk({name, ".session_active"}, 32'(session_active), 32'd0);
    @(negedge clk);
    chk({name, ".one_cycle"}, 32'(pulses), 32'(P_NONE));
    $display("%s: timeout after %0d cycles", name, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    //                card  acc    pv  pin     act lo  unl uidx   pulses  sa  ej  tries idx
    vecs[0]  = mk(1, 4'd3,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd0, 4'd0);
    vecs[1]  = mk(1, 4'd3,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd2);
    vecs[2]  = mk(1, 4'd3,  1, 16'd3456, 0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd2);
    vecs[3]  = mk(1, 4'd3,  0, 16'd0,    0, 0, 0, 4'd0, P_OK,   1, 0, 2'd3, 4'd2);
    vecs[4]  = mk(1, 4'd3,  0, 16'd0,    0, 1, 0, 4'd0, P_NONE, 0, 1, 2'd3, 4'd2);
    vecs[5]  = mk(0, 4'd3,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd2);
    vecs[6]  = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd2);
    vecs[7]  = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd4);
    vecs[8]  = mk(1, 4'd5,  1, 16'd1111, 0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd4);
    vecs[9]  = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_FAIL, 0, 0, 2'd2, 4'd4);
    vecs[10] = mk(1, 4'd5,  1, 16'd2222, 0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd2, 4'd4);
    vecs[11] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_FAIL, 0, 0, 2'd1, 4'd4);
    vecs[12] = mk(1, 4'd5,  1, 16'd3333, 0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd1, 4'd4);
    vecs[13] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_LOCK, 0, 1, 2'd0, 4'd4);
    vecs[14] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 1, 2'd0, 4'd4);
    vecs[15] = mk(0, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd0, 4'd4);
    vecs[16] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd0, 4'd4);
    vecs[17] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_REJ,  0, 1, 2'd0, 4'd4);
    vecs[18] = mk(0, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd0, 4'd4);
    vecs[19] = mk(0, 4'd5,  0, 16'd0,    0, 0, 1, 4'd4, P_NONE, 0, 0, 2'd0, 4'd4);
    vecs[20] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd0, 4'd4);
    vecs[21] = mk(1, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd4);
    vecs[22] = mk(0, 4'd5,  0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd4);
    vecs[23] = mk(1, 4'd12, 0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd4);
    vecs[24] = mk(1, 4'd12, 0, 16'd0,    0, 0, 0, 4'd0, P_REJ,  0, 1, 2'd3, 4'd4);
    vecs[25] = mk(1, 4'd12, 1, 16'd5678, 1, 1, 0, 4'd0, P_NONE, 0, 1, 2'd3, 4'd4);
    vecs[26] = mk(0, 4'd12, 0, 16'd0,    0, 0, 0, 4'd0, P_NONE, 0, 0, 2'd3, 4'd4);
    vecs[27] = mk(0, 4'd5,  1, 16'd5678, 1, 1, 1, 4'd12, P_NONE, 0, 0, 2'd3, 4'd4);

    rst_n        = 1'b0;
    card_in      = 1'b0;
    acc_num      = '0;
    pin_valid    = 1'b0;
    pin          = '0;
    activity     = 1'b0;
    logout       = 1'b0;
    admin_unlock = 1'b0;
    unlock_index = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("reset", P_NONE, 0, 0, 2'd0, 4'd0);
    chk("reset.auth_acc_num", 32'(auth_acc_num), 32'd0);
    chk("reset.auth_pin", 32'(auth_pin), 32'd0);

    for (int i = 0; i < NV; i++) begin
      card_in      = vecs[i].card;
      acc_num      = vecs[i].acc;
      pin_valid    = vecs[i].pv;
      pin          = vecs[i].pin;
      activity     = vecs[i].act;
      logout       = vecs[i].lo;
      admin_unlock = vecs[i].unl;
      unlock_index = vecs[i].uidx;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].ep, vecs[i].esa, vecs[i].eej, vecs[i].etr, vecs[i].eidx);
    end
    card_in = 1'b0; pin_valid = 1'b0; activity = 1'b0; logout = 1'b0; admin_unlock = 1'b0;
    @(negedge clk);

    // WAIT_PIN inactivity timeout.
    insert(4'd4);
    chk_outs("wp_enter", P_NONE, 0, 0, 2'd3, 4'd3);
    run_to_timeout(TO, "wp_timeout");
    remove_card();

    // ACTIVE inactivity timeout.
    insert(4'd1);
    pin_try(16'd1234, 1'b0, 4'd0);
    chk_outs("act_enter", P_OK, 1, 0, 2'd3, 4'd0);
    run_to_timeout(TO, "act_timeout");
    remove_card();

    // Activity just before expiry restarts the full timeout window.
    insert(4'd1);
    pin_try(16'd1234, 1'b0, 4'd0);
    chk_outs("act2_enter", P_OK, 1, 0, 2'd3, 4'd0);
    seen = 0;
    for (int t = 0; t < TO - 2; t++) begin
      @(negedge clk);
      if (timeout) seen++;
    end
    activity = 1'b1;
    @(negedge clk);
    activity = 1'b0;
    if (timeout) seen++;
    chk("activity.no_timeout", 32'(seen), 32'd0);
    chk("activity.session_active", 32'(session_active), 32'd1);
    run_to_timeout(TO, "activity_timeout");
    remove_card();

    // Card pulled while the second attempt is being checked.
    insert(4'd7);
    pin_try(16'd1, 1'b0, 4'd0);
    chk_outs("drop_try1", P_FAIL, 0, 0, 2'd2, 4'd6);
    pin_valid = 1'b1;
    pin       = 16'd2;
    @(negedge clk);
    pin_valid = 1'b0;
    card_in   = 1'b0;
    @(negedge clk);
    chk_outs("drop_check", P_NONE, 0, 0, 2'd2, 4'd6);
    @(negedge clk);
    chk_outs("drop_idle", P_NONE, 0, 0, 2'd2, 4'd6);
    insert(4'd7);
    chk_outs("drop_reinsert", P_NONE, 0, 0, 2'd3, 4'd6);
    remove_card();

    // Lock set and admin unlock collide on the same index; the lock must stick.
    insert(4'd2);
    pin_try(16'd1, 1'b0, 4'd0);
    chk_outs("collide_try1", P_FAIL, 0, 0, 2'd2, 4'd1);
    pin_try(16'd2, 1'b0, 4'd0);
    chk_outs("collide_try2", P_FAIL, 0, 0, 2'd1, 4'd1);
    pin_try(16'd3, 1'b1, 4'd1);
    chk_outs("collide_try3", P_LOCK, 0, 1, 2'd0, 4'd1);
    remove_card();
    insert(4'd2);
    chk_outs("collide_reinsert", P_REJ, 0, 1, 2'd0, 4'd1);
    remove_card();

    // Asynchronous reset in the middle of a session clears everything without a clock edge.
    insert(4'd3);
    pin_try(16'd3456, 1'b0, 4'd0);
    chk_outs("rst_active", P_OK, 1, 0, 2'd3, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rst_async", P_NONE, 0, 0, 2'd0, 4'd0);
    chk("rst_async.auth_acc_num", 32'(auth_acc_num), 32'd0);
    chk("rst_async.auth_pin", 32'(auth_pin), 32'd0);
    card_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    insert(4'd2);
    chk_outs("rst_lock_cleared", P_NONE, 0, 0, 2'd3, 4'd1);
    remove_card();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
